// File: rtl/mem_stage.sv
// LEGv8 memory stage: EX/MEM and MEM/WB pipeline registers, branch resolution,
// and a req/ack data-memory port with a bounded wait and a sticky fault.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_RUN   | no access outstanding; zero-wait accesses complete here
//   S_WAIT  | access issued, waiting for mem_ack; cnt = request cycles seen
//   S_FAULT | ack never arrived; pipeline frozen until reset
module mem_stage #(
    parameter int N        = 64,
    parameter int WAIT_MAX = 15
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         valid_E,
    input  logic         Branch_E,
    input  logic         UncondBranch_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic         RegWrite_E,
    input  logic         MemtoReg_E,
    input  logic [4:0]   Rd_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic         zero_E,

    output logic         stall_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,

    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         mem_fault,

    output logic         valid_W,
    output logic         RegWrite_W,
    output logic         MemtoReg_W,
    output logic [4:0]   Rd_W,
    output logic [N-1:0] aluResult_W,
    output logic [N-1:0] readData_W
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          valid_M;
    logic          Branch_M;
    logic          UncondBranch_M;
    logic          MemRead_M;
    logic          MemWrite_M;
    logic          RegWrite_M;
    logic          MemtoReg_M;
    logic          zero_M;
    logic [4:0]    Rd_M;
    logic [N-1:0]  aluResult_M;
    logic [N-1:0]  writeData_M;

    logic          mem_op_M;

    assign mem_op_M  = valid_M & (MemRead_M | MemWrite_M);
    assign mem_req   = mem_op_M & (state != S_FAULT);
    assign mem_we    = MemWrite_M;
    assign mem_addr  = aluResult_M;
    assign mem_wdata = writeData_M;
    assign stall_M   = (mem_op_M & ~mem_ack) | (state == S_FAULT);
    assign PCSrc_M   = valid_M & (UncondBranch_M | (Branch_M & zero_M));

    // EX/MEM: holding on stall keeps the request fields stable until ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_M        <= 1'b0;
            Branch_M       <= 1'b0;
            UncondBranch_M <= 1'b0;
            MemRead_M      <= 1'b0;
            MemWrite_M     <= 1'b0;
            RegWrite_M     <= 1'b0;
            MemtoReg_M     <= 1'b0;
            zero_M         <= 1'b0;
            Rd_M           <= '0;
            PCBranch_M     <= '0;
            aluResult_M    <= '0;
            writeData_M    <= '0;
        end else if (!stall_M) begin
            valid_M        <= valid_E & ~PCSrc_M;
            Branch_M       <= Branch_E;
            UncondBranch_M <= UncondBranch_E;
            MemRead_M      <= MemRead_E;
            MemWrite_M     <= MemWrite_E;
            RegWrite_M     <= RegWrite_E;
            MemtoReg_M     <= MemtoReg_E;
            zero_M         <= zero_E;
            Rd_M           <= Rd_E;
            PCBranch_M     <= PCBranch_E;
            aluResult_M    <= aluResult_E;
            writeData_M    <= writeData_E;
        end
    end

    // MEM/WB: a stalled cycle sends a clean bubble to writeback.
    always_ff @(posedge clk) begin
        if (reset || stall_M) begin
            valid_W     <= 1'b0;
            RegWrite_W  <= 1'b0;
            MemtoReg_W  <= 1'b0;
            Rd_W        <= '0;
            aluResult_W <= '0;
            readData_W  <= '0;
        end else begin
            valid_W     <= valid_M;
            RegWrite_W  <= RegWrite_M & valid_M;
            MemtoReg_W  <= MemtoReg_M;
            Rd_W        <= Rd_M;
            aluResult_W <= aluResult_M;
            readData_W  <= MemRead_M ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            cnt       <= '0;
            mem_fault <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (mem_req && !mem_ack) begin
                        state <= S_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        state <= S_RUN;
                        cnt   <= '0;
                    end else if (cnt == CW'(WAIT_MAX)) begin
                        state     <= S_FAULT;
                        mem_fault <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage in the LEGv8 pipelined datapath.
- Holds the EX/MEM pipeline register and resolves CBZ/B branches (PCSrc_M, PCBranch_M).
- Performs LDUR/STUR through a req/ack data-memory handshake, stalling upstream while the access is pending.
- Drives the MEM/WB pipeline register.

Parameters:
- N, 64, datapath width.
- WAIT_MAX, 15, maximum cycles req may wait for ack before fault (1..255).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- valid_E  in  1  EX holds a real instruction.
- Branch_E, UncondBranch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E  in  1 each  control bits from EX.
- Rd_E  in  5  destination register.
- PCBranch_E, aluResult_E, writeData_E  in  N  execute outputs.
- zero_E  in  1  ALU zero flag.
- stall_M  out  1  hold all upstream stages this cycle.
- PCSrc_M  out  1  redirect fetch to PCBranch_M.
- PCBranch_M  out  N  registered branch target.
- mem_req, mem_we  out  1  request valid; write (1) / read (0).
- mem_addr, mem_wdata  out  N  address (aluResult_M); store data (writeData_M).
- mem_ack  in  1  access complete this cycle.
- mem_rdata  in  N  load data, valid with mem_ack.
- mem_fault  out  1  sticky timeout flag.
- valid_W, RegWrite_W, MemtoReg_W  out  1  MEM/WB control.
- Rd_W  out  5; aluResult_W, readData_W  out  N  MEM/WB data.

Behaviour:
- Reset: every register cleared to 0. All outputs are 0, state is RUN, and the wait counter is 0.
- mem_op_M = valid_M & (MemRead_M | MemWrite_M).
- mem_req = mem_op_M & state != FAULT. This is combinational from the M register.
- mem_we = MemWrite_M. mem_addr and mem_wdata are taken from the M register.
- Request fields stay stable while mem_req=1 and mem_ack=0.
- stall_M = mem_op_M & !mem_ack, or state==FAULT.
- PCSrc_M = valid_M & (UncondBranch_M | (Branch_M & zero_M)). It is combinational.
- A branch is never a mem op, so PCSrc_M is high for exactly one cycle per taken branch.
- EX/MEM register:
  - If stall_M, hold all fields.
  - Else if PCSrc_M, capture with valid_M=0 (the younger instruction is squashed); other fields are don't-care.
  - Else capture all _E inputs.
- MEM/WB register:
  - If stall_M, load valid_W=0 (bubble to WB). RegWrite_W, MemtoReg_W and Rd_W are forced to 0.
  - Else load valid_W=valid_M, RegWrite_W=RegWrite_M&valid_M, MemtoReg_W, Rd_W and aluResult_W.
  - readData_W = mem_rdata if MemRead_M, else 0.
- Zero-wait memory: with mem_ack in the same cycle as req, a load/store completes in 1 cycle with no stall.
- FSM:
  - RUN: if mem_req & !mem_ack, go to WAIT with cnt=1.
  - WAIT: if mem_ack, go to RUN with cnt=0. Else if cnt==WAIT_MAX, go to FAULT and set mem_fault=1. Else cnt++.
  - FAULT: terminal until reset. mem_req=0, stall_M=1, MEM/WB receives bubbles.
- mem_ack while mem_req=0 is ignored and has no state effect.
- Reset mid-access: mem_req drops the next cycle. The pending access is abandoned, and memory must tolerate req withdrawal on reset only.
- Widths: cnt is $clog2(WAIT_MAX+1) bits. No arithmetic on the datapath besides pass-through.

Test Plan:
- Zero-wait load: STUR then LDUR at addr 0x10, data 0xDEAD_BEEF; ack same cycle as req.
  - Required: readData_W=0xDEADBEEF one cycle after the LDUR is in M.
  - Required: stall_M never high; mem_we=1 for the STUR and 0 for the LDUR.
- 3-wait load: ack arrives on the 4th req cycle.
  - Required: stall_M high for exactly 3 cycles.
  - Required: mem_addr/mem_wdata unchanged throughout.
  - Required: valid_W=0 for 3 cycles, then valid_W=1 with the loaded data.
- CBZ taken: zero_E=1, Branch_E=1, PCBranch_E=0x400, followed by valid add.
  - Required: PCSrc_M=1 for 1 cycle with PCBranch_M=0x400.
  - Required: the following instruction appears as valid_W=0, RegWrite_W=0.
- CBZ not taken (zero_E=0) and B (UncondBranch_E=1):
  - Required: PCSrc_M 0 and 1 respectively.
  - Required: an instruction with valid_E=0 never asserts PCSrc_M.
- Timeout: with WAIT_MAX=15, mem_ack held 0.
  - Required: mem_fault rises after 16 req cycles; then mem_req=0 and stall_M=1 permanently.
  - Required: reset clears everything to 0.
- Reset during a WAIT (cycle 2):
  - Required: next cycle all outputs 0, state RUN.
  - Required: a subsequent zero-wait load completes normally.
